fir_sample_buffer: RTL and testbench

//  Input stage of the FIR filter. Accepts samples over a valid/ready stream.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_tap_ring.sv | 67 ++++++
 rtl/fir_sample_buffer.sv | 79 +++++++
 tb/tb_fir_sample_buffer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fir_pkg                                                     |
// | Brief  : Shared types and width helper for the FIR sample buffer.    |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package fir_pkg;

    typedef enum logic [1:0] {
        BUF_IDLE = 2'd0,
        BUF_REQ  = 2'd1,
        BUF_BUSY = 2'd2
    } buf_state_t;

    // Width of an address counter that must also reach the value n itself.
    function automatic int tap_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tap_ring.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fir_tap_ring                                                |
// | Brief  : Sample ring with wrap pointer, fill count and masked tap    |
// |          read port (tap k = x[n-k], zero beyond the fill level).     |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module fir_tap_ring
    import fir_pkg::*;
#(
    parameter int COEFF_COUNT = 64,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             wr_en,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [tap_w(COEFF_COUNT)-1:0]    tap_addr,
    output logic [DATA_WIDTH-1:0]            tap_data,
    output logic [tap_w(COEFF_COUNT)-1:0]    fill_cnt
);

    localparam int             c_AW    = $clog2(COEFF_COUNT);
    localparam int             c_TW    = tap_w(COEFF_COUNT);
    localparam logic [c_TW:0]  c_DEPTH = (c_TW + 1)'(COEFF_COUNT);

    logic [DATA_WIDTH-1:0] r_mem [COEFF_COUNT];
    logic [c_AW-1:0]       r_wptr;
    logic [c_TW-1:0]       r_fill;
    logic [c_TW:0]         w_sum;
    logic [c_AW-1:0]       w_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_fill <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_fill <= '0;
        end else if (wr_en) begin
            r_wptr <= (r_wptr == c_AW'(COEFF_COUNT - 1)) ? '0 : r_wptr + c_AW'(1);
            if (r_fill != c_TW'(COEFF_COUNT))
                r_fill <= r_fill + c_TW'(1);
        end
    end

    // Contents are never cleared; the fill mask hides stale entries.
    always_ff @(posedge clk) begin
        if (wr_en)
            r_mem[r_wptr] <= wr_data;
    end

    // idx = (wptr - 1 - k) mod depth via one add-back of the depth.
    always_comb begin
        w_sum    = {{(c_TW + 1 - c_AW){1'b0}}, r_wptr} + c_DEPTH - (c_TW + 1)'(1)
                   - {1'b0, tap_addr};
        w_idx    = c_AW'((w_sum >= c_DEPTH) ? w_sum - c_DEPTH : w_sum);
        tap_data = '0;
        if (({1'b0, tap_addr} < c_DEPTH) && (tap_addr < r_fill))
            tap_data = r_mem[w_idx];
    end

    assign fill_cnt = r_fill;

endmodule
`default_nettype wire

// File: rtl/fir_sample_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fir_sample_buffer                                           |
// | Brief  : FIR input stage: stream handshake, one request per sample,  |
// |          holds off the next sample until the frame is done.          |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module fir_sample_buffer
    import fir_pkg::*;
#(
    parameter int COEFF_COUNT = 64,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             in_ready,
    output logic                             fir_req,
    input  logic                             fir_done,
    input  logic [tap_w(COEFF_COUNT)-1:0]    tap_addr,
    output logic [DATA_WIDTH-1:0]            tap_data,
    output logic [tap_w(COEFF_COUNT)-1:0]    fill_cnt
);

    buf_state_t r_state;
    buf_state_t w_state_nxt;
    logic       w_accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= BUF_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        fir_req     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            BUF_IDLE: begin
                in_ready = !flush;
                w_accept = in_valid && !flush;
                if (w_accept)
                    w_state_nxt = BUF_REQ;
            end
            BUF_REQ: begin
                fir_req     = 1'b1;
                w_state_nxt = BUF_BUSY;
            end
            BUF_BUSY: begin
                if (fir_done)
                    w_state_nxt = BUF_IDLE;
            end
            default: w_state_nxt = BUF_IDLE;
        endcase
        if (flush)
            w_state_nxt = BUF_IDLE;
    end

    fir_tap_ring #(
        .COEFF_COUNT (COEFF_COUNT),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_en    (w_accept),
        .wr_data  (in_data),
        .tap_addr (tap_addr),
        .tap_data (tap_data),
        .fill_cnt (fill_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_fir_sample_buffer                                        |
// | Brief  : Randomized scoreboard bench for fir_sample_buffer (4 taps). |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_fir_sample_buffer;

    localparam int C  = 4;
    localparam int DW = 16;
    localparam int TW = $clog2(C) + 1;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          fir_req;
    logic          fir_done;
    logic [TW-1:0] tap_addr;
    logic [DW-1:0] tap_data;
    logic [TW-1:0] fill_cnt;

    typedef struct packed {
        logic [C:0][DW-1:0] taps;
        logic [TW-1:0]      fill;
    } exp_t;

    exp_t sb[$];
    int   hist[$];
    bit   pending = 0;
    bit   mon_en  = 1;
    int   n_vec   = 0;
    int   n_err   = 0;

    fir_sample_buffer #(.COEFF_COUNT(C), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .fir_req  (fir_req),
        .fir_done (fir_done),
        .tap_addr (tap_addr),
        .tap_data (tap_data),
        .fill_cnt (fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: newest sample first, at most C kept, zero beyond history.
    function automatic exp_t make_exp();
        exp_t e;
        for (int k = 0; k <= C; k++)
            e.taps[k] = (k < hist.size()) ? DW'(hist[k]) : '0;
        e.fill = TW'(hist.size());
        return e;
    endfunction

    task automatic model_push(input logic [DW-1:0] d);
        hist.push_front(int'(d));
        if (hist.size() > C)
            void'(hist.pop_back());
    endtask

    // Monitor: acts as the FIR FSM, sweeping every tap once per request.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && fir_req) begin
                exp_t e;
                if (sb.size() == 0) begin
                    chk("req_without_sample", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    for (int k = 0; k <= C; k++) begin
                        @(negedge clk);
                        tap_addr = TW'(k);
                        #1;
                        chk($sformatf("tap%0d", k), 32'(tap_data), 32'(e.taps[k]));
                        if (k == 0) begin
                            chk("fill_cnt", 32'(fill_cnt), 32'(e.fill));
                            chk("fir_req_width", 32'(fir_req), 32'd0);
                            chk("in_ready_busy", 32'(in_ready), 32'd0);
                        end
                    end
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    fir_done = 1'b1;
                    @(negedge clk);
                    fir_done = 1'b0;
                    pending  = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit fl;
        bit v;
        int t;
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        fir_done = 1'b0;
        tap_addr = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_fir_req",  32'(fir_req),  32'd0);
        chk("rst_fill_cnt", 32'(fill_cnt), 32'd0);
        chk("rst_tap_data", 32'(tap_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            #1;
            v        = ($urandom_range(0, 2) != 0);
            in_valid = v;
            in_data  = DW'($urandom);
            if (!pending) begin
                fl    = ($urandom_range(0, 9) == 0);
                flush = fl;
                #1;
                chk("in_ready_idle", 32'(in_ready), 32'(!fl));
                if (fl) begin
                    hist.delete();
                end else if (v) begin
                    model_push(in_data);
                    sb.push_back(make_exp());
                    pending = 1'b1;
                end
            end else begin
                flush = 1'b0;
                #1;
                chk("in_ready_held", 32'(in_ready), 32'd0);
            end
        end
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        t = 0;
        while ((pending || sb.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(pending || sb.size() != 0), 32'd0);

        // Asynchronous reset while the FIR frame is in progress.
        mon_en = 1'b0;
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 16'd9;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("dir_req", 32'(fir_req), 32'd1);
        @(negedge clk);
        #1;
        chk("dir_busy_ready", 32'(in_ready), 32'd0);
        #1;
        rst = 1'b0;
        tap_addr = '0;
        #1;
        chk("async_in_ready", 32'(in_ready), 32'd1);
        chk("async_fir_req",  32'(fir_req),  32'd0);
        chk("async_fill_cnt", 32'(fill_cnt), 32'd0);
        chk("async_tap0",     32'(tap_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        hist.delete();
        fir_done = 1'b1;
        @(negedge clk);
        fir_done = 1'b0;
        #1;
        chk("done_ignored_ready", 32'(in_ready), 32'd1);
        chk("done_ignored_req",   32'(fir_req),  32'd0);
        chk("done_ignored_fill",  32'(fill_cnt), 32'd0);

        // Fresh history after reset: new sample at tap 0, rest zero.
        mon_en   = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        model_push(in_data);
        sb.push_back(make_exp());
        pending = 1'b1;
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        t = 0;
        while ((pending || sb.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_final", 32'(pending || sb.size() != 0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
